// File: rtl/register_bank_sb_if.sv
// Decode/writeback-side bundle of the register bank: read ports, ALU write, load scoreboard
// traffic and link register.
interface register_bank_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rh_addr;
  logic [ADDR_WIDTH-1:0] ro_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rh_value;
  logic [DATA_WIDTH-1:0] ro_value;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  rh_busy;
  logic                  ro_busy;
  logic                  rd_busy;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  ld_issue;
  logic [ADDR_WIDTH-1:0] ld_issue_addr;
  logic                  ld_issue_err;
  logic                  ld_done;
  logic [ADDR_WIDTH-1:0] ld_done_addr;
  logic [DATA_WIDTH-1:0] ld_done_data;

  logic                  link_wr_en;
  logic [DATA_WIDTH-1:0] link_data;
  logic [DATA_WIDTH-1:0] link_value;

  modport master (
    output rh_addr, ro_addr, rd_addr,
    input  rh_value, ro_value, rd_value, rh_busy, ro_busy, rd_busy,
    output wr_en, wr_addr, wr_data,
    output ld_issue, ld_issue_addr,
    input  ld_issue_err,
    output ld_done, ld_done_addr, ld_done_data,
    output link_wr_en, link_data,
    input  link_value
  );

  modport slave (
    input  rh_addr, ro_addr, rd_addr,
    output rh_value, ro_value, rd_value, rh_busy, ro_busy, rd_busy,
    input  wr_en, wr_addr, wr_data,
    input  ld_issue, ld_issue_addr,
    output ld_issue_err,
    input  ld_done, ld_done_addr, ld_done_data,
    input  link_wr_en, link_data,
    output link_value
  );
endinterface

// File: rtl/register_bank_sb.sv
// Register bank with three combinational read ports, ALU and load-return write ports, link
// register, optional write-first bypass and a per-register load scoreboard (busy/stale).
module register_bank_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned BYPASS_EN  = 1
) (
  input logic              clock,
  input logic              reset,
  register_bank_sb_if.slave bus
);

  localparam int unsigned NumRegs  = 2 ** ADDR_WIDTH;
  localparam int unsigned NumPorts = 3;

  // Encoding is {busy, stale}.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBusy  = 2'b10,
    StStale = 2'b01
  } reg_state_e;

  logic [DATA_WIDTH-1:0] regs_q  [NumRegs];
  logic [DATA_WIDTH-1:0] regs_d  [NumRegs];
  reg_state_e            state_q [NumRegs];
  reg_state_e            state_d [NumRegs];
  logic [DATA_WIDTH-1:0] link_q;
  logic [DATA_WIDTH-1:0] link_d;
  logic                  ld_issue_err_q;
  logic                  ld_issue_err_d;

  // Next-state for array, scoreboard, link and issue error.
  always_comb begin
    regs_d         = regs_q;
    state_d        = state_q;
    link_d         = bus.link_wr_en ? bus.link_data : link_q;
    ld_issue_err_d = 1'b0;

    for (int unsigned i = 0; i < NumRegs; i++) begin
      logic is_zero;
      logic wr_hit;
      logic done_hit;
      logic issue_hit;
      is_zero   = (ZERO_REG != 0) && (i == 0);
      wr_hit    = bus.wr_en    && (bus.wr_addr       == ADDR_WIDTH'(i));
      done_hit  = bus.ld_done  && (bus.ld_done_addr  == ADDR_WIDTH'(i));
      issue_hit = bus.ld_issue && (bus.ld_issue_addr == ADDR_WIDTH'(i));

      if (!is_zero) begin
        unique case (state_q[i])
          StIdle:  state_d[i] = StIdle;
          StBusy: begin
            if (done_hit) begin
              state_d[i] = StIdle;
            end else if (wr_hit) begin
              state_d[i] = StStale;
            end
          end
          StStale: begin
            if (done_hit) begin
              state_d[i] = StIdle;
            end
          end
          default: state_d[i] = StIdle;
        endcase

        // ALU data wins; load data only lands on a register still waiting for it.
        if (wr_hit) begin
          regs_d[i] = bus.wr_data;
        end else if (done_hit && (state_q[i] == StBusy)) begin
          regs_d[i] = bus.ld_done_data;
        end

        // Issue sees the register after this cycle's write/done have been applied.
        if (issue_hit) begin
          if (state_d[i] == StIdle) begin
            state_d[i] = StBusy;
          end else begin
            ld_issue_err_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i]  <= '0;
        state_q[i] <= StIdle;
      end
      link_q         <= '0;
      ld_issue_err_q <= 1'b0;
    end else begin
      regs_q         <= regs_d;
      state_q        <= state_d;
      link_q         <= link_d;
      ld_issue_err_q <= ld_issue_err_d;
    end
  end

  logic [ADDR_WIDTH-1:0] rd_port_addr  [NumPorts];
  logic [DATA_WIDTH-1:0] rd_port_value [NumPorts];
  logic                  rd_port_busy  [NumPorts];

  assign rd_port_addr[0] = bus.rh_addr;
  assign rd_port_addr[1] = bus.ro_addr;
  assign rd_port_addr[2] = bus.rd_addr;

  always_comb begin
    for (int unsigned p = 0; p < NumPorts; p++) begin
      rd_port_value[p] = regs_q[rd_port_addr[p]];
      rd_port_busy[p]  = (state_q[rd_port_addr[p]] == StBusy);

      if (BYPASS_EN != 0) begin
        if (bus.wr_en && (bus.wr_addr == rd_port_addr[p])) begin
          rd_port_value[p] = bus.wr_data;
          rd_port_busy[p]  = 1'b0;
        end else if (bus.ld_done && (bus.ld_done_addr == rd_port_addr[p]) &&
                     (state_q[rd_port_addr[p]] == StBusy)) begin
          rd_port_value[p] = bus.ld_done_data;
          rd_port_busy[p]  = 1'b0;
        end
      end

      if ((ZERO_REG != 0) && (rd_port_addr[p] == '0)) begin
        rd_port_value[p] = '0;
        rd_port_busy[p]  = 1'b0;
      end
    end
  end

  assign bus.rh_value     = rd_port_value[0];
  assign bus.ro_value     = rd_port_value[1];
  assign bus.rd_value     = rd_port_value[2];
  assign bus.rh_busy      = rd_port_busy[0];
  assign bus.ro_busy      = rd_port_busy[1];
  assign bus.rd_busy      = rd_port_busy[2];
  assign bus.ld_issue_err = ld_issue_err_q;
  assign bus.link_value   = link_q;

endmodule

// File: tb/tb_register_bank_sb.sv
// Scoreboard bench: two bank configurations driven in lockstep, compared against a
// rule-level model of registers, load scoreboard, link and issue error.
module tb_register_bank_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int IDLE = 0;
  localparam int BUSY = 1;
  localparam int STALE = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  register_bank_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  register_bank_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  register_bank_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS_EN(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  register_bank_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS_EN(0)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct packed {
    logic          reset;
    logic [AW-1:0] rh_addr;
    logic [AW-1:0] ro_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          ld_issue;
    logic [AW-1:0] ld_issue_addr;
    logic          ld_done;
    logic [AW-1:0] ld_done_addr;
    logic [DW-1:0] ld_done_data;
    logic          link_wr_en;
    logic [DW-1:0] link_data;
  } stim_t;

  typedef struct packed {
    logic [1:0][2:0][DW-1:0] val;
    logic [1:0][2:0]         busy;
    logic [1:0]              err;
    logic [1:0][DW-1:0]      link;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: config 0 = plain bank with bypass, config 1 = zero reg, no bypass.
  bit            cfg_zero [2] = '{1'b0, 1'b1};
  bit            cfg_byp  [2] = '{1'b1, 1'b0};
  logic [DW-1:0] m_regs [2][NR];
  int            m_st   [2][NR];
  logic          m_err  [2];
  logic [DW-1:0] m_link [2];

  function automatic void model_read(input int c, input logic [AW-1:0] a, input stim_t s,
                                     output logic [DW-1:0] v, output logic b);
    if (cfg_zero[c] && a == 0) begin
      v = '0;
      b = 1'b0;
    end else if (cfg_byp[c] && s.wr_en && s.wr_addr == a) begin
      v = s.wr_data;
      b = 1'b0;
    end else if (cfg_byp[c] && s.ld_done && s.ld_done_addr == a && m_st[c][a] == BUSY) begin
      v = s.ld_done_data;
      b = 1'b0;
    end else begin
      v = m_regs[c][a];
      b = (m_st[c][a] == BUSY);
    end
  endfunction

  function automatic void model_edge(input stim_t s);
    for (int c = 0; c < 2; c++) begin
      if (s.reset) begin
        for (int i = 0; i < NR; i++) begin
          m_regs[c][i] = '0;
          m_st[c][i]   = IDLE;
        end
        m_err[c]  = 1'b0;
        m_link[c] = '0;
      end else begin
        int a;
        // Load return first, then ALU write, then issue against the resulting state.
        a = int'(s.ld_done_addr);
        if (s.ld_done && !(cfg_zero[c] && a == 0)) begin
          if (m_st[c][a] == BUSY) begin
            if (!(s.wr_en && s.wr_addr == s.ld_done_addr)) m_regs[c][a] = s.ld_done_data;
            m_st[c][a] = IDLE;
          end else if (m_st[c][a] == STALE) begin
            m_st[c][a] = IDLE;
          end
        end
        a = int'(s.wr_addr);
        if (s.wr_en && !(cfg_zero[c] && a == 0)) begin
          m_regs[c][a] = s.wr_data;
          if (m_st[c][a] == BUSY) m_st[c][a] = STALE;
        end
        m_err[c] = 1'b0;
        a = int'(s.ld_issue_addr);
        if (s.ld_issue && !(cfg_zero[c] && a == 0)) begin
          if (m_st[c][a] == IDLE) m_st[c][a] = BUSY;
          else m_err[c] = 1'b1;
        end
        if (s.link_wr_en) m_link[c] = s.link_data;
      end
    end
  endfunction

  task automatic drive(input stim_t s);
    reset                = s.reset;
    bus_a.rh_addr        = s.rh_addr;        bus_b.rh_addr        = s.rh_addr;
    bus_a.ro_addr        = s.ro_addr;        bus_b.ro_addr        = s.ro_addr;
    bus_a.rd_addr        = s.rd_addr;        bus_b.rd_addr        = s.rd_addr;
    bus_a.wr_en          = s.wr_en;          bus_b.wr_en          = s.wr_en;
    bus_a.wr_addr        = s.wr_addr;        bus_b.wr_addr        = s.wr_addr;
    bus_a.wr_data        = s.wr_data;        bus_b.wr_data        = s.wr_data;
    bus_a.ld_issue       = s.ld_issue;       bus_b.ld_issue       = s.ld_issue;
    bus_a.ld_issue_addr  = s.ld_issue_addr;  bus_b.ld_issue_addr  = s.ld_issue_addr;
    bus_a.ld_done        = s.ld_done;        bus_b.ld_done        = s.ld_done;
    bus_a.ld_done_addr   = s.ld_done_addr;   bus_b.ld_done_addr   = s.ld_done_addr;
    bus_a.ld_done_data   = s.ld_done_data;   bus_b.ld_done_data   = s.ld_done_data;
    bus_a.link_wr_en     = s.link_wr_en;     bus_b.link_wr_en     = s.link_wr_en;
    bus_a.link_data      = s.link_data;      bus_b.link_data      = s.link_data;
  endtask

  // One clock: drive, queue the expected view of this cycle, advance the model at the edge.
  task automatic cycle(input stim_t s, input bit chk);
    exp_t e;
    logic [DW-1:0] v;
    logic b;
    drive(s);
    if (chk) begin
      e = '0;
      for (int c = 0; c < 2; c++) begin
        model_read(c, s.rh_addr, s, v, b); e.val[c][0] = v; e.busy[c][0] = b;
        model_read(c, s.ro_addr, s, v, b); e.val[c][1] = v; e.busy[c][1] = b;
        model_read(c, s.rd_addr, s, v, b); e.val[c][2] = v; e.busy[c][2] = b;
        e.err[c]  = m_err[c];
        e.link[c] = m_link[c];
      end
      exp_q.push_back(e);
    end
    @(posedge clock);
    model_edge(s);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_cfg(input int c, input exp_t e,
                           input logic [DW-1:0] rh, input logic [DW-1:0] ro,
                           input logic [DW-1:0] rd, input logic rhb, input logic rob,
                           input logic rdb, input logic err, input logic [DW-1:0] link);
    check($sformatf("cfg%0d rh_value", c), rh, e.val[c][0]);
    check($sformatf("cfg%0d ro_value", c), ro, e.val[c][1]);
    check($sformatf("cfg%0d rd_value", c), rd, e.val[c][2]);
    check($sformatf("cfg%0d rh_busy", c), DW'(rhb), DW'(e.busy[c][0]));
    check($sformatf("cfg%0d ro_busy", c), DW'(rob), DW'(e.busy[c][1]));
    check($sformatf("cfg%0d rd_busy", c), DW'(rdb), DW'(e.busy[c][2]));
    check($sformatf("cfg%0d ld_issue_err", c), DW'(err), DW'(e.err[c]));
    check($sformatf("cfg%0d link_value", c), link, e.link[c]);
  endtask

  // Monitor: outputs are stable mid-cycle; pop whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_cfg(0, e, bus_a.rh_value, bus_a.ro_value, bus_a.rd_value, bus_a.rh_busy,
                  bus_a.ro_busy, bus_a.rd_busy, bus_a.ld_issue_err, bus_a.link_value);
        check_cfg(1, e, bus_b.rh_value, bus_b.ro_value, bus_b.rd_value, bus_b.rh_busy,
                  bus_b.ro_busy, bus_b.rd_busy, bus_b.ld_issue_err, bus_b.link_value);
      end
    end
  end

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s               = '0;
    s.reset         = ($urandom_range(0, 99) == 0);
    s.rh_addr       = pick_addr();
    s.ro_addr       = pick_addr();
    s.rd_addr       = pick_addr();
    s.wr_en         = ($urandom_range(0, 99) < 40);
    s.wr_addr       = pick_addr();
    s.wr_data       = $urandom;
    s.ld_issue      = ($urandom_range(0, 99) < 35);
    s.ld_issue_addr = pick_addr();
    s.ld_done       = ($urandom_range(0, 99) < 40);
    s.ld_done_addr  = pick_addr();
    s.ld_done_data  = $urandom;
    s.link_wr_en    = ($urandom_range(0, 99) < 20);
    s.link_data     = $urandom;
    return s;
  endfunction

  initial begin
    stim_t s;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[c][i] = '0;
        m_st[c][i]   = IDLE;
      end
      m_err[c]  = 1'b0;
      m_link[c] = '0;
    end

    // Reset; outputs before the first edge are unknown so that cycle is not checked.
    s = '0; s.reset = 1'b1;
    cycle(s, 1'b0);
    cycle(s, 1'b1);

    // Write r5 with same-cycle read, then plain read.
    s = '0; s.wr_en = 1'b1; s.wr_addr = 5; s.wr_data = 32'hDEADBEEF; s.rh_addr = 5;
    cycle(s, 1'b1);
    s = '0; s.rh_addr = 5;
    cycle(s, 1'b1);

    // Load issue / return on r7.
    s = '0; s.ld_issue = 1'b1; s.ld_issue_addr = 7; s.ro_addr = 7;
    cycle(s, 1'b1);
    s = '0; s.ro_addr = 7;
    cycle(s, 1'b1);
    s = '0; s.ld_done = 1'b1; s.ld_done_addr = 7; s.ld_done_data = 32'h1234; s.ro_addr = 7;
    cycle(s, 1'b1);
    s = '0; s.ro_addr = 7;
    cycle(s, 1'b1);

    // Stale path on r3, including rejected re-issue.
    s = '0; s.ld_issue = 1'b1; s.ld_issue_addr = 3; s.rd_addr = 3;
    cycle(s, 1'b1);
    s = '0; s.wr_en = 1'b1; s.wr_addr = 3; s.wr_data = 32'hAA; s.rd_addr = 3;
    cycle(s, 1'b1);
    s = '0; s.ld_issue = 1'b1; s.ld_issue_addr = 3; s.rd_addr = 3;
    cycle(s, 1'b1);
    s = '0; s.ld_done = 1'b1; s.ld_done_addr = 3; s.ld_done_data = 32'hBB; s.rd_addr = 3;
    cycle(s, 1'b1);
    s = '0; s.rd_addr = 3;
    cycle(s, 1'b1);

    // Write and load return collide on busy r9; load return to idle r10.
    s = '0; s.ld_issue = 1'b1; s.ld_issue_addr = 9; s.rh_addr = 9;
    cycle(s, 1'b1);
    s = '0; s.wr_en = 1'b1; s.wr_addr = 9; s.wr_data = 32'h5555;
    s.ld_done = 1'b1; s.ld_done_addr = 9; s.ld_done_data = 32'h6666; s.rh_addr = 9;
    cycle(s, 1'b1);
    s = '0; s.rh_addr = 9; s.ld_done = 1'b1; s.ld_done_addr = 10; s.ld_done_data = 32'h77;
    s.ro_addr = 10;
    cycle(s, 1'b1);
    s = '0; s.rh_addr = 9; s.ro_addr = 10;
    cycle(s, 1'b1);

    // Register 0 write and link register.
    s = '0; s.wr_en = 1'b1; s.wr_addr = 0; s.wr_data = 32'hFFFF; s.link_wr_en = 1'b1;
    s.link_data = 32'h40;
    cycle(s, 1'b1);
    s = '0; s.rh_addr = 0;
    cycle(s, 1'b1);

    // Reset overrides a pending load and a same-cycle write.
    s = '0; s.ld_issue = 1'b1; s.ld_issue_addr = 2; s.rd_addr = 2;
    cycle(s, 1'b1);
    s = '0; s.reset = 1'b1; s.wr_en = 1'b1; s.wr_addr = 2; s.wr_data = 32'h1; s.rd_addr = 2;
    s.rh_addr = 5; s.ro_addr = 7;
    cycle(s, 1'b1);
    s = '0; s.rd_addr = 2; s.rh_addr = 5; s.ro_addr = 7;
    cycle(s, 1'b1);

    // Randomised traffic with heavy address collisions.
    for (int n = 0; n < 3000; n++) begin
      cycle(rand_stim(), 1'b1);
    end

    s = '0;
    drive(s);
    repeat (2) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
